// File: rtl/mem_apb_ws_if.sv
// APB bus bundle for mem_apb_ws: master drives the request, slave returns
// PRDATA/PREADY/PSLVERR.
interface mem_apb_ws_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic            PSEL;
   logic            PENABLE;
   logic [AW-1:0]   PADDR;
   logic            PWRITE;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [2:0]      PPROT;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/mem_apb_ws.sv
// APB slave memory with WAIT access-phase wait states, byte strobes and
// misalignment errors. Define MEM_APB_PROT_CHECK_EN to reject unprivileged writes at or above PROT_BASE.
module mem_apb_ws #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int LEN       = 8,
   parameter int WAIT      = 0,
   parameter int PROT_BASE = 2 ** (LEN - 1)
) (
   input  logic         PCLK,
   input  logic         PRESET,
   mem_apb_ws_if.slave  bus
);
   localparam int BW    = DW / 8;
   localparam int OFF   = $clog2(BW);
   localparam int IW    = LEN - OFF;
   localparam int DEPTH = 2 ** IW;
   localparam logic [3:0]     WAIT_C   = 4'(WAIT);
   localparam logic [LEN-1:0] PROT_OFF = LEN'(PROT_BASE);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;
   logic [IW-1:0]   r_idx;
   logic            r_write;
   logic            r_err;
   logic [DW-1:0]   r_rdata;
   logic [DW-1:0]   w_rdata_nxt;
   logic [DW-1:0]   r_mem [DEPTH];

   logic            w_setup;
   logic            w_misalign;
   logic            w_prot_err;
   logic            w_err_bus;
   logic [IW-1:0]   w_idx_bus;
   logic            w_ready;
   logic            w_do_write;
   logic            w_rd_load;
   logic [IW-1:0]   w_rd_idx;
   logic            w_rd_write;
   logic            w_rd_err;
   logic            w_unused_bits;

   assign w_setup    = bus.PSEL & ~bus.PENABLE;
   assign w_idx_bus  = bus.PADDR[LEN-1:OFF];
   assign w_misalign = (bus.PADDR[OFF-1:0] != {OFF{1'b0}});

`ifdef MEM_APB_PROT_CHECK_EN
   assign w_prot_err    = bus.PWRITE & ~bus.PPROT[0] & (bus.PADDR[LEN-1:0] >= PROT_OFF);
   assign w_unused_bits = ^{bus.PADDR[AW-1:LEN], bus.PPROT[2:1]};
`else
   assign w_prot_err    = 1'b0;
   assign w_unused_bits = ^{bus.PADDR[AW-1:LEN], bus.PPROT, PROT_OFF};
`endif

   assign w_err_bus  = w_misalign | w_prot_err;
   assign w_ready    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
   assign w_do_write = w_ready & bus.PSEL & r_write & ~r_err;

   assign bus.PREADY  = w_ready;
   assign bus.PSLVERR = w_ready & r_err;
   assign bus.PRDATA  = r_rdata;

   // Next state, wait counter and read-data capture
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_setup) begin
               w_state_nxt = S_ACCESS;
               w_cnt_nxt   = WAIT_C;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         S_ACCESS: begin
            if (!bus.PSEL) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else if (r_cnt != 4'd0) begin
               w_state_nxt = S_ACCESS;
               w_cnt_nxt   = r_cnt - 4'd1;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase

      // With WAIT=0 the final access cycle follows setup, so read straight off the bus
      if (r_state == S_IDLE) begin
         w_rd_idx   = w_idx_bus;
         w_rd_write = bus.PWRITE;
         w_rd_err   = w_err_bus;
      end else begin
         w_rd_idx   = r_idx;
         w_rd_write = r_write;
         w_rd_err   = r_err;
      end

      w_rd_load = (w_state_nxt == S_ACCESS) && (w_cnt_nxt == 4'd0);
      if (w_rd_load && !w_rd_write && !w_rd_err) begin
         w_rdata_nxt = r_mem[w_rd_idx];
      end else begin
         w_rdata_nxt = {DW{1'b0}};
      end
   end

   // Control state, latched request and read data
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= {IW{1'b0}};
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= {DW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rdata <= w_rdata_nxt;
         if (r_state == S_IDLE && w_setup) begin
            r_idx   <= w_idx_bus;
            r_write <= bus.PWRITE;
            r_err   <= w_err_bus;
         end
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge PCLK) begin
      if (w_do_write) begin
         for (int b = 0; b < BW; b++) begin
            if (bus.PSTRB[b]) begin
               r_mem[r_idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_apb_ws.sv
// Scoreboard bench for mem_apb_ws: three instances (WAIT=0,3,5) share one
// driver; a negedge monitor pops expected responses whenever PREADY is seen.
module tb_mem_apb_ws;
   logic        clk;
   logic        rst;
   logic [1:0]  dut;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        m_ready;
   logic        m_err;
   logic [31:0] m_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   acc_cnt  = 0;

   mem_apb_ws_if bif0 ();
   mem_apb_ws_if bif1 ();
   mem_apb_ws_if bif2 ();

   mem_apb_ws #(.WAIT(0)) u0 (.PCLK(clk), .PRESET(rst), .bus(bif0.slave));
   mem_apb_ws #(.WAIT(3)) u1 (.PCLK(clk), .PRESET(rst), .bus(bif1.slave));
   mem_apb_ws #(.WAIT(5)) u2 (.PCLK(clk), .PRESET(rst), .bus(bif2.slave));

   assign bif0.PSEL = psel && (dut == 2'd0);
   assign bif1.PSEL = psel && (dut == 2'd1);
   assign bif2.PSEL = psel && (dut == 2'd2);
   assign bif0.PENABLE = penable; assign bif1.PENABLE = penable; assign bif2.PENABLE = penable;
   assign bif0.PADDR   = paddr;   assign bif1.PADDR   = paddr;   assign bif2.PADDR   = paddr;
   assign bif0.PWRITE  = pwrite;  assign bif1.PWRITE  = pwrite;  assign bif2.PWRITE  = pwrite;
   assign bif0.PWDATA  = pwdata;  assign bif1.PWDATA  = pwdata;  assign bif2.PWDATA  = pwdata;
   assign bif0.PSTRB   = pstrb;   assign bif1.PSTRB   = pstrb;   assign bif2.PSTRB   = pstrb;
   assign bif0.PPROT   = pprot;   assign bif1.PPROT   = pprot;   assign bif2.PPROT   = pprot;

   assign m_ready = (dut == 2'd0) ? bif0.PREADY  : (dut == 2'd1) ? bif1.PREADY  : bif2.PREADY;
   assign m_err   = (dut == 2'd0) ? bif0.PSLVERR : (dut == 2'd1) ? bif1.PSLVERR : bif2.PSLVERR;
   assign m_rdata = (dut == 2'd0) ? bif0.PRDATA  : (dut == 2'd1) ? bif1.PRDATA  : bif2.PRDATA;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: count access cycles, compare against scoreboard on PREADY
   always @(negedge clk) begin
      if (rst || !(psel && penable)) begin
         acc_cnt = 0;
      end else begin
         acc_cnt++;
         if (m_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("prdata", m_rdata, e.rdata);
               chk("pslverr", {31'd0, m_err}, {31'd0, e.err});
               chk("latency", acc_cnt, e.lat);
            end
            acc_cnt = 0;
         end
      end
   end

   function automatic int lat_of(input logic [1:0] d);
      return (d == 2'd0) ? 1 : (d == 2'd1) ? 4 : 6;
   endfunction

   // One complete transfer; leaves the bus at posedge+1 with PSEL still high
   // so the next call forms a back-to-back transfer unless idle() intervenes.
   task automatic xfer(input logic [1:0] d, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                       input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      int   n;
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat_of(d);
      sb.push_back(e);
      dut = d; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr;
      pwdata = wd; pstrb = st; pprot = pr;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) chk("ready_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      penable = 1'b0;
   endtask

   task automatic idle();
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic        prot_err;
      logic [31:0] prot_rd;
`ifdef MEM_APB_PROT_CHECK_EN
      prot_err = 1'b1; prot_rd = 32'h0000_00AA;
`else
      prot_err = 1'b0; prot_rd = 32'h0000_0005;
`endif
      dut = 2'd0; psel = 1'b0; penable = 1'b0; paddr = 32'd0; pwrite = 1'b0;
      pwdata = 32'd0; pstrb = 4'd0; pprot = 3'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", {31'd0, bif0.PREADY}, 32'd0);
      chk("rst_err1", {31'd0, bif1.PSLVERR}, 32'd0);
      chk("rst_rdata2", bif2.PRDATA, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // WAIT=0: basic, strobes, errors, back-to-back aliasing, protection
      xfer(2'd0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b0, 32'h10, 32'd0, 4'h0, 3'd1, 32'hDEADBEEF, 1'b0);
      xfer(2'd0, 1'b1, 32'h04, 32'h11223344, 4'hF, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b0, 32'h04, 32'd0, 4'h0, 3'd1, 32'h11BB33DD, 1'b0);
      xfer(2'd0, 1'b1, 32'h04, 32'h55667788, 4'h0, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b0, 32'h04, 32'd0, 4'h0, 3'd1, 32'h11BB33DD, 1'b0);
      idle();
      xfer(2'd0, 1'b0, 32'h03, 32'd0, 4'h0, 3'd1, 32'd0, 1'b1);
      xfer(2'd0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 3'd1, 32'd0, 1'b1);
      xfer(2'd0, 1'b0, 32'h10, 32'd0, 4'h0, 3'd1, 32'hDEADBEEF, 1'b0);
      xfer(2'd0, 1'b1, 32'h104, 32'h0BADF00D, 4'hF, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b0, 32'h004, 32'd0, 4'h0, 3'd1, 32'h0BADF00D, 1'b0);
      xfer(2'd0, 1'b1, 32'h80, 32'h000000AA, 4'hF, 3'd1, 32'd0, 1'b0);
      xfer(2'd0, 1'b1, 32'h80, 32'h00000005, 4'hF, 3'd0, 32'd0, prot_err);
      xfer(2'd0, 1'b0, 32'h80, 32'd0, 4'h0, 3'd0, prot_rd, 1'b0);
      idle();

      // WAIT=3: latency and PSEL-drop abort
      xfer(2'd1, 1'b1, 32'h20, 32'h20202020, 4'hF, 3'd1, 32'd0, 1'b0);
      xfer(2'd1, 1'b0, 32'h20, 32'd0, 4'h0, 3'd1, 32'h20202020, 1'b0);
      idle();
      dut = 2'd1; psel = 1'b1; penable = 1'b0; paddr = 32'h20; pwrite = 1'b1;
      pwdata = 32'h99999999; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", {31'd0, bif1.PREADY}, 32'd0);
      xfer(2'd1, 1'b0, 32'h20, 32'd0, 4'h0, 3'd1, 32'h20202020, 1'b0);
      idle();

      // WAIT=5: reset on the 2nd access cycle aborts the write
      xfer(2'd2, 1'b1, 32'h08, 32'h01234567, 4'hF, 3'd1, 32'd0, 1'b0);
      idle();
      dut = 2'd2; psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1;
      pwdata = 32'hCAFE0000; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_ready", {31'd0, bif2.PREADY}, 32'd0);
      chk("rst_mid_err", {31'd0, bif2.PSLVERR}, 32'd0);
      chk("rst_mid_rdata", bif2.PRDATA, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(2'd2, 1'b0, 32'h08, 32'd0, 4'h0, 3'd1, 32'h01234567, 1'b0);
      idle();

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_apb_ws.md
MEM_APB_WS -- requirements
Module: mem_apb_ws

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning PADDR width.
REQ-002 The block SHALL have parameter DW, default 32, meaning PRDATA/PWDATA width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter LEN, default 8, meaning byte-address bits decoded; depth is 2^LEN/(DW/8) words.
REQ-004 The block SHALL have parameter WAIT, default 0, meaning access-phase wait states; legal range is 0..15.
REQ-005 The block SHALL have parameter PROT_BASE, default 2^(LEN-1), meaning the byte offset at which the privileged-write region starts.
REQ-006 The block SHALL have port PCLK, input, width 1: the single clock, rising-edge active.
REQ-007 The block SHALL have port PRESET, input, width 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port PSEL, input, width 1: slave select.
REQ-009 The block SHALL have port PENABLE, input, width 1: access-phase indicator.
REQ-010 The block SHALL have port PADDR, input, width AW: byte address; only bits [LEN-1:0] are used.
REQ-011 The block SHALL have port PWRITE, input, width 1: 1 = write, 0 = read.
REQ-012 The block SHALL have port PWDATA, input, width DW: write data.
REQ-013 The block SHALL have port PSTRB, input, width DW/8: byte-lane write strobes.
REQ-014 The block SHALL have port PPROT, input, width 3: protection; bit 0 = privileged.
REQ-015 The block SHALL have port PRDATA, output, width DW: read data.
REQ-016 The block SHALL have port PREADY, output, width 1: transfer completion.
REQ-017 The block SHALL have port PSLVERR, output, width 1: error response, valid only while PREADY=1.

Function
REQ-018 The block SHALL implement a state machine with states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-019 IDLE -> ACCESS: on a setup cycle (PSEL=1, PENABLE=0), the block SHALL load the counter with WAIT and register the address, direction and error flag.
REQ-020 In ACCESS with PSEL=1 and counter>0, the block SHALL decrement the counter and hold PREADY=0.
REQ-021 PREADY SHALL be 1 exactly when state=ACCESS and counter=0; the latency from setup is therefore WAIT+1 cycles.
REQ-022 On the cycle PREADY=1, a non-error write SHALL update only the byte lanes where PSTRB=1; PSTRB=0 SHALL write nothing.
REQ-023 For a read, PRDATA SHALL be registered from memory no later than the edge entering the final access cycle and held while PREADY=1; otherwise PRDATA SHALL be 0.
REQ-024 Misalignment: if PADDR[log2(DW/8)-1:0] is nonzero, the block SHALL set PSLVERR=1 with PREADY, perform no write, and return PRDATA=0.
REQ-025 After completion the block SHALL return to IDLE; a setup cycle in the next cycle SHALL start a new transfer with no extra bubble (back-to-back).
REQ-026 If PSEL falls while in ACCESS before completion, the block SHALL return to IDLE, perform no write, and keep PREADY=0.
REQ-027 The word address SHALL be PADDR[LEN-1:log2(DW/8)]; upper address bits SHALL be ignored, so addresses alias with wrap-around at 2^LEN.
REQ-028 Outside ACCESS, PREADY, PSLVERR and PRDATA SHALL be 0.

Reset
REQ-029 PRESET=1 SHALL asynchronously force IDLE, counter=0, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-030 Memory contents SHALL NOT be reset and are undefined after power-up.
REQ-031 A reset asserted mid-transfer SHALL abort it with no write performed.
REQ-032 The first setup cycle after PRESET falls SHALL be accepted normally.

Configuration
REQ-033 The macro MEM_APB_PROT_CHECK_EN SHALL control protection checking.
REQ-034 When MEM_APB_PROT_CHECK_EN is defined, a write with PPROT[0]=0 to an offset >= PROT_BASE SHALL complete with PSLVERR=1 and no memory update; reads SHALL be unaffected.
REQ-035 When MEM_APB_PROT_CHECK_EN is undefined, PPROT SHALL be ignored and no protection error SHALL ever occur.

Verification
REQ-036 Zero-wait write then read: WAIT=0, write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 -> PREADY=1 on the first access cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-037 Wait states: WAIT=3, read 0x20 -> PREADY held low for 3 access cycles and high on the 4th.
REQ-038 Strobes: write 0x11223344 to 0x04 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5 -> a read of 0x04 returns 0x11BB33DD.
REQ-039 Error cases: read of 0x03 -> PSLVERR=1 and PRDATA=0; with MEM_APB_PROT_CHECK_EN and PPROT=0, write 0x5 to 0x80 -> PSLVERR=1 and the old contents are retained.
REQ-040 Reset mid-access: WAIT=5, write 0xCAFE0000 to 0x08, assert PRESET on the 2nd access cycle -> PREADY=0 immediately; a later read of 0x08 returns the pre-write value.
REQ-041 Back-to-back and aliasing: WAIT=0, write to 0x104, then immediately read 0x004 -> the read returns the data just written, with no idle cycle between the transfers.
